// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax max-subtract front end.
//   - FP32 constants used by the datapath.
//   - Controller state encoding.
//   - Small FP32 helpers: -0 normalisation, NaN test, ordered compare key.
package softmax_pkg;

   localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
   localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
   localparam int          SOFTMAX_N     = 13;

   typedef enum logic [1:0] {
      S_LOAD,
      S_OUT,
      S_DONE
   } state_e;

   // -0 and +0 must look identical to both the compare and the equality
   // test that forces a zero result.
   function automatic logic [31:0] fp32_norm(input logic [31:0] x);
      return (x == FP32_NEG_ZERO) ? FP32_ZERO : x;
   endfunction

   function automatic logic fp32_is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Maps FP32 onto an unsigned key whose integer order equals the
   // numeric order (negatives inverted, positives lifted above them).
   function automatic logic [31:0] fp32_key(input logic [31:0] x);
      return x[31] ? ~x : (x ^ 32'h8000_0000);
   endfunction

endpackage

// File: rtl/add_sub.sv
// FP32 adder, round-to-nearest-even, subnormals supported.
// Ports:
//   a_i, b_i : FP32 operands
//   y_o      : FP32 sum a_i + b_i (any NaN or +Inf + -Inf gives quiet NaN)
module add_sub (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] y_o
);

   logic        a_nan, b_nan, a_inf, b_inf, swap;
   logic [31:0] big, sml;
   logic [7:0]  big_e, sml_e, shift;
   logic [23:0] big_m, sml_m;
   logic [49:0] sml_sh;
   logic [26:0] big_x, sml_x, norm;
   logic [27:0] sum;
   logic [4:0]  lz;
   logic        found, rnd_up;
   logic [9:0]  exp_r, sh;
   logic [24:0] rnd;

   always_comb begin
      // NOTE: every variable gets a value on every path before use, so no latch is inferred.
      a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
      b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
      a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
      b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);

      // Larger magnitude first so the subtract never goes negative.
      swap   = b_i[30:0] > a_i[30:0];
      big    = swap ? b_i : a_i;
      sml    = swap ? a_i : b_i;

      // Subnormals use exponent 1 with no hidden bit.
      big_e  = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      sml_e  = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      big_m  = {big[30:23] != 8'd0, big[22:0]};
      sml_m  = {sml[30:23] != 8'd0, sml[22:0]};
      shift  = big_e - sml_e;

      // Alignment keeps guard and round bits; everything lower folds into sticky.
      sml_sh = {sml_m, 26'd0} >> shift;
      sml_x  = {sml_sh[49:24], |sml_sh[23:0]};
      big_x  = {big_m, 3'b000};

      if (big[31] == sml[31]) sum = {1'b0, big_x} + {1'b0, sml_x};
      else                    sum = {1'b0, big_x} - {1'b0, sml_x};

      exp_r = {2'b00, big_e};
      lz    = 5'd0;
      found = 1'b0;
      sh    = 10'd0;
      if (sum[27]) begin
         norm  = {sum[27:2], sum[1] | sum[0]};
         exp_r = exp_r + 10'd1;
      end else begin
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz    = lz + 5'd1;
            end
         end
         // Left shift stops at exponent 1; anything smaller stays subnormal.
         sh    = ({5'd0, lz} >= exp_r) ? exp_r - 10'd1 : {5'd0, lz};
         norm  = sum[26:0] << sh;
         exp_r = exp_r - sh;
      end

      rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
      if (rnd[24]) begin
         rnd   = rnd >> 1;
         exp_r = exp_r + 10'd1;
      end

      y_o = {big[31], rnd[23] ? exp_r[7:0] : 8'd0, rnd[22:0]};
      if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) y_o = 32'h7FC0_0000;
      else if (a_inf)              y_o = a_i;
      else if (b_inf)              y_o = b_i;
      else if (sum == 28'd0)       y_o = {big[31] & sml[31], 31'd0};
      else if (exp_r >= 10'd255)   y_o = {big[31], 8'hFF, 23'd0};
   end

endmodule

// File: rtl/softmax_max_sub_fp32_gt.sv
// Strict FP32 greater-than for running-max tracking.
// Ports:
//   a_i, b_i : FP32 values, already -0 normalised, b_i never NaN
//   gt_o     : a_i > b_i numerically (ties give 0)
//   a_nan_o  : a_i is a NaN (caller must ignore gt_o then)
module fp32_gt
   import softmax_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        gt_o,
   output logic        a_nan_o
);

   assign gt_o    = fp32_key(a_i) > fp32_key(b_i);
   assign a_nan_o = fp32_is_nan(a_i);

endmodule

// File: rtl/softmax_max_sub.sv
// Softmax numerical-stability front end: buffers one vector of N FP32
// logits while tracking the maximum, then streams x[i] - max in order.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_data/in_ready     : input element stream
//   out_valid/out_data/out_idx/
//   out_last/out_ready            : shifted-element stream
//   max_val                       : running / final maximum
//   nan_seen                      : a NaN arrived in this vector
//   done                          : one-cycle pulse after last output
module softmax_max_sub
   import softmax_pkg::*;
#(
   parameter int N     = SOFTMAX_N,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [31:0]      out_data,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   input  logic             out_ready,
   output logic [31:0]      max_val,
   output logic             nan_seen,
   output logic             done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_e           state_q;
   logic [IDX_W-1:0] wr_idx_q, rd_idx_q, out_idx_q;
   logic [31:0]      max_q, max_d, out_data_q;
   logic             have_max_q, nan_seen_q;
   logic             in_ready_q, out_valid_q, out_last_q, done_q;
   logic [31:0]      buf_q [N];

   logic             accept, handshake, in_gt, in_nan;
   logic [31:0]      in_norm, rd_data, sub_b, sub_y, result_d;
   logic [IDX_W-1:0] sel_idx;

   assign accept    = in_valid & in_ready_q;
   assign handshake = out_valid_q & out_ready;
   assign in_norm   = fp32_norm(in_data);

   fp32_gt u_gt (
      .a_i     (in_norm),
      .b_i     (max_q),
      .gt_o    (in_gt),
      .a_nan_o (in_nan)
   );

   // First non-NaN loads directly; later ones need to be strictly greater.
   always_comb begin
      max_d = max_q;
      if (accept && !in_nan && (!have_max_q || in_gt)) max_d = in_norm;
   end

   // Index of the element to present next: element 0 on the final load,
   // otherwise the successor of the one being handed off.
   assign sel_idx = (state_q == S_LOAD) ? '0 : rd_idx_q + 1'b1;

   always_comb begin
      rd_data = FP32_ZERO;
      if (sel_idx <= LAST_IDX) rd_data = buf_q[sel_idx];
   end

   // max_d already includes the last element when element 0 is prepared.
   assign sub_b = {~max_d[31], max_d[30:0]};

   add_sub u_sub (
      .a_i (rd_data),
      .b_i (sub_b),
      .y_o (sub_y)
   );

   always_comb begin
      result_d = sub_y;
      if (fp32_is_nan(rd_data))  result_d = FP32_QNAN;
      else if (rd_data == max_d) result_d = FP32_ZERO;
   end

   // NOTE: the element store has no reset; its contents are meaningless until rewritten.
   always_ff @(posedge clk) begin
      if (accept) buf_q[wr_idx_q] <= in_norm;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_LOAD;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         max_q       <= FP32_ZERO;
         have_max_q  <= 1'b0;
         nan_seen_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= FP32_ZERO;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         max_q  <= max_d;
         unique case (state_q)
            S_LOAD: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  wr_idx_q <= wr_idx_q + 1'b1;
                  if (in_nan) nan_seen_q <= 1'b1;
                  else        have_max_q <= 1'b1;
                  if (wr_idx_q == LAST_IDX) begin
                     state_q     <= S_OUT;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_data_q  <= result_d;
                     out_idx_q   <= '0;
                     out_last_q  <= 1'b0;
                     rd_idx_q    <= '0;
                  end
               end
            end
            S_OUT: begin
               if (handshake) begin
                  if (rd_idx_q == LAST_IDX) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     rd_idx_q   <= sel_idx;
                     out_idx_q  <= sel_idx;
                     out_data_q <= result_d;
                     out_last_q <= (sel_idx == LAST_IDX);
                  end
               end
            end
            S_DONE: begin
               state_q    <= S_LOAD;
               in_ready_q <= 1'b1;
               wr_idx_q   <= '0;
               rd_idx_q   <= '0;
               nan_seen_q <= 1'b0;
               have_max_q <= 1'b0;
               max_q      <= FP32_ZERO;
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign max_val   = max_q;
   assign nan_seen  = nan_seen_q;
   assign done      = done_q;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Scoreboard bench for softmax_max_sub: an N=3 instance for most vectors
// and an N=13 instance for a full logit vector.
module tb_softmax_max_sub;

   typedef struct {
      logic [31:0] data;
      logic [31:0] mask;
      logic [3:0]  idx;
      logic        last;
      logic [31:0] maxv;
      logic        nan;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst3 = 1'b1, in_valid3 = 1'b0, out_ready3 = 1'b1;
   logic [31:0] in_data3 = '0;
   logic        in_ready3, out_valid3, out_last3, nan_seen3, done3;
   logic [31:0] out_data3, max_val3;
   logic [1:0]  out_idx3;

   logic        rst13 = 1'b1, in_valid13 = 1'b0, out_ready13 = 1'b1;
   logic [31:0] in_data13 = '0;
   logic        in_ready13, out_valid13, out_last13, nan_seen13, done13;
   logic [31:0] out_data13, max_val13;
   logic [3:0]  out_idx13;

   softmax_max_sub #(.N(3), .IDX_W(2)) dut3 (
      .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_idx(out_idx3), .out_last(out_last3),
      .out_ready(out_ready3), .max_val(max_val3), .nan_seen(nan_seen3), .done(done3)
   );

   softmax_max_sub #(.N(13), .IDX_W(4)) dut13 (
      .clk(clk), .rst(rst13), .in_valid(in_valid13), .in_data(in_data13), .in_ready(in_ready13),
      .out_valid(out_valid13), .out_data(out_data13), .out_idx(out_idx13), .out_last(out_last13),
      .out_ready(out_ready13), .max_val(max_val13), .nan_seen(nan_seen13), .done(done13)
   );

   int   n_total = 0, n_pass = 0;
   exp_t sb3[$], sb13[$];
   bit   exp_done3 = 1'b0, exp_done13 = 1'b0;

   logic [31:0] logits13 [13] = '{
      32'hBE559B3D, 32'hBE773190, 32'hBE77B4A2, 32'hBE843FE6, 32'hBE866666,
      32'h3FDBF141, 32'h3FE1B717, 32'h408DF3B6, 32'h40EF652C, 32'h4125793E,
      32'h415D5A86, 32'h41A04BFB, 32'h417FFF97};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   task automatic exp3(input logic [31:0] d, input logic [3:0] i, input logic l,
                       input logic [31:0] m, input logic n);
      sb3.push_back('{data: d, mask: 32'hFFFF_FFFF, idx: i, last: l, maxv: m, nan: n});
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!rst3) begin
         if (exp_done3) begin
            check("done3", 32'(done3), 32'd1);
            check("in_ready3_during_done", 32'(in_ready3), 32'd0);
            exp_done3 = 1'b0;
         end
         if (out_valid3) begin
            if (sb3.size() == 0) begin
               n_total++;
               $display("FAIL out3_unexpected: got idx %0d expected no output", out_idx3);
            end else begin
               e = sb3[0];
               check($sformatf("out_data3[%0d]", e.idx), out_data3 & e.mask, e.data & e.mask);
               check("out_idx3", 32'(out_idx3), 32'(e.idx));
               check("out_last3", 32'(out_last3), 32'(e.last));
               check("max_val3", max_val3, e.maxv);
               check("nan_seen3", 32'(nan_seen3), 32'(e.nan));
               if (out_ready3) begin
                  void'(sb3.pop_front());
                  if (e.last) exp_done3 = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst13) begin
         if (exp_done13) begin
            check("done13", 32'(done13), 32'd1);
            exp_done13 = 1'b0;
         end
         if (out_valid13) begin
            if (sb13.size() == 0) begin
               n_total++;
               $display("FAIL out13_unexpected: got idx %0d expected no output", out_idx13);
            end else begin
               e = sb13[0];
               check($sformatf("out_data13[%0d]", e.idx), out_data13 & e.mask, e.data & e.mask);
               check("out_idx13", 32'(out_idx13), 32'(e.idx));
               check("out_last13", 32'(out_last13), 32'(e.last));
               check("max_val13", max_val13, e.maxv);
               if (out_ready13) begin
                  void'(sb13.pop_front());
                  if (e.last) exp_done13 = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- drivers (called just after a rising edge) ----------------
   task automatic push3(input logic [31:0] x);
      int n = 0;
      while (!in_ready3 && n < 50) begin @(posedge clk); #2; n++; end
      if (!in_ready3) timeout("push3");
      in_valid3 = 1'b1;
      in_data3  = x;
      @(posedge clk); #2;
      in_valid3 = 1'b0;
   endtask

   task automatic push13(input logic [31:0] x);
      int n = 0;
      while (!in_ready13 && n < 50) begin @(posedge clk); #2; n++; end
      if (!in_ready13) timeout("push13");
      in_valid13 = 1'b1;
      in_data13  = x;
      @(posedge clk); #2;
      in_valid13 = 1'b0;
   endtask

   task automatic drain3();
      int n = 0;
      while ((sb3.size() != 0 || exp_done3) && n < 200) begin @(posedge clk); #2; n++; end
      if (sb3.size() != 0 || exp_done3) timeout("drain3");
   endtask

   task automatic drain13();
      int n = 0;
      while ((sb13.size() != 0 || exp_done13) && n < 200) begin @(posedge clk); #2; n++; end
      if (sb13.size() != 0 || exp_done13) timeout("drain13");
   endtask

   task automatic check_reset3(input string tag);
      check({tag, "_in_ready"},  32'(in_ready3),  32'd0);
      check({tag, "_out_valid"}, 32'(out_valid3), 32'd0);
      check({tag, "_out_data"},  out_data3,       32'd0);
      check({tag, "_out_idx"},   32'(out_idx3),   32'd0);
      check({tag, "_out_last"},  32'(out_last3),  32'd0);
      check({tag, "_max_val"},   max_val3,        32'd0);
      check({tag, "_nan_seen"},  32'(nan_seen3),  32'd0);
      check({tag, "_done"},      32'(done3),      32'd0);
   endtask

   task automatic vec132();
      exp3(32'hC000_0000, 4'd0, 1'b0, 32'h4040_0000, 1'b0);
      exp3(32'h0000_0000, 4'd1, 1'b0, 32'h4040_0000, 1'b0);
      exp3(32'hBF80_0000, 4'd2, 1'b1, 32'h4040_0000, 1'b0);
      push3(32'h3F80_0000);
      push3(32'h4040_0000);
      push3(32'h4000_0000);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      repeat (2) @(posedge clk);
      #2;
      check_reset3("rst3");
      check("rst13_in_ready",  32'(in_ready13),  32'd0);
      check("rst13_out_valid", 32'(out_valid13), 32'd0);
      check("rst13_max_val",   max_val13,        32'd0);
      rst3  = 1'b0;
      rst13 = 1'b0;
      @(posedge clk); #2;
      check("in_ready3_after_release", 32'(in_ready3), 32'd1);

      // 1, 3, 2
      vec132();
      drain3();

      // full logit vector on the 13-wide instance
      for (int i = 0; i < 13; i++)
         sb13.push_back('{data: (i == 11) ? 32'h0 : 32'h8000_0000,
                          mask: (i == 11) ? 32'hFFFF_FFFF : 32'h8000_0000,
                          idx: 4'(i), last: (i == 12), maxv: 32'h41A04BFB, nan: 1'b0});
      for (int i = 0; i < 13; i++) push13(logits13[i]);
      drain13();

      // -0, +0, -1
      exp3(32'h0000_0000, 4'd0, 1'b0, 32'h0000_0000, 1'b0);
      exp3(32'h0000_0000, 4'd1, 1'b0, 32'h0000_0000, 1'b0);
      exp3(32'hBF80_0000, 4'd2, 1'b1, 32'h0000_0000, 1'b0);
      push3(32'h8000_0000);
      push3(32'h0000_0000);
      push3(32'hBF80_0000);
      drain3();

      // NaN, 1, 1
      exp3(32'h7FC0_0000, 4'd0, 1'b0, 32'h3F80_0000, 1'b1);
      exp3(32'h0000_0000, 4'd1, 1'b0, 32'h3F80_0000, 1'b1);
      exp3(32'h0000_0000, 4'd2, 1'b1, 32'h3F80_0000, 1'b1);
      push3(32'h7FC0_0001);
      push3(32'h3F80_0000);
      push3(32'h3F80_0000);
      drain3();

      // backpressure on idx 1, with a stray input pulse while streaming
      vec132();
      n = 0;
      while (!(out_valid3 && out_idx3 == 2'd1) && n < 20) begin @(posedge clk); #2; n++; end
      if (!(out_valid3 && out_idx3 == 2'd1)) timeout("wait_idx1");
      out_ready3 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            in_valid3 = 1'b1;
            in_data3  = 32'h40A0_0000;
            check("in_ready3_in_out_state", 32'(in_ready3), 32'd0);
         end else begin
            in_valid3 = 1'b0;
         end
         @(posedge clk); #2;
      end
      in_valid3  = 1'b0;
      out_ready3 = 1'b1;
      drain3();

      // abort after two of three inputs
      push3(32'h3F80_0000);
      push3(32'h4040_0000);
      rst3 = 1'b1;
      #1;
      check_reset3("abort3");
      @(posedge clk); #2;
      rst3 = 1'b0;
      vec132();
      drain3();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
